change_dispenser: RTL
=====================

Name: change_dispenser

Overview:
- Downstream of the vending-machine top: consumes the change amount (charge_val, charge_float) when charge_ind asserts.
- Pays the change out one coin at a time through a request/acknowledge handshake with three coin hoppers (5 yuan, 1 yuan, 0.5 yuan).
- Uses greedy largest-coin-first selection, falls back to smaller coins when a hopper is empty, and reports progress, completion and faults.

Parameters:
- ACK_TIMEOUT, 16, cycles to wait for hop_ack after hop_req before declaring a fault.
- GAP_CYCLES, 2, idle cycles inserted between consecutive coin requests.
- CNT_W, 5, width of the timeout/gap counter; must hold max(ACK_TIMEOUT, GAP_CYCLES).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- charge_ind  input  1  change pending; a start is its rising edge as seen in IDLE.
- charge_val  input  5  integer-yuan part of the change.
- charge_float  input  1  1 = an extra 0.5 yuan.
- hop_empty  input  3  per-hopper empty flags: bit2 = 5 yuan, bit1 = 1 yuan, bit0 = 0.5 yuan.
- hop_ack  input  1  single-cycle pulse from the hopper: one coin ejected.
- hop_req  output  1  coin request, held until acked or timed out.
- hop_sel  output  2  hopper select, valid while hop_req is high: 2'b10 = 5 yuan, 2'b01 = 1 yuan, 2'b00 = 0.5 yuan.
- busy  output  1  high from start until DONE or FAULT.
- done  output  1  one-cycle pulse when the remaining amount reaches 0.
- fault  output  1  sticky error flag.
- remain_val  output  6  remaining change in half-yuan units.

Behaviour:
- Amount arithmetic:
  - H = {charge_val, charge_float}, i.e. charge_val*2 + charge_float; range 0..63.
  - Coin weights in half-yuan units: 5 yuan = 10, 1 yuan = 2, 0.5 yuan = 1.
  - H is latched into the remain register at start; charge inputs are ignored afterwards until return to IDLE.
- Reset (reset low at a clock edge): state = IDLE; hop_req = 0, hop_sel = 0, busy = 0, done = 0, fault = 0, remain_val = 0; counters cleared; edge-detect register cleared to 0.
  - Reset mid-payout aborts immediately.
  - An already-acknowledged coin is not re-requested.
- IDLE:
  - On a charge_ind rising edge: latch H and set busy = 1.
  - If H == 0: go to DONE.
  - Otherwise: go to SELECT.
- SELECT (one cycle), greedy choice:
  - Choose 5 yuan if remain >= 10 and !hop_empty[2].
  - Else 1 yuan if remain >= 2 and !hop_empty[1].
  - Else 0.5 yuan if remain >= 1 and !hop_empty[0].
  - Else go to FAULT.
  - On a valid choice, drive hop_sel and go to REQ.
- REQ: assert hop_req on the next cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - On hop_ack: drop hop_req the same edge; subtract the coin weight from remain.
    - If the result is 0: go to DONE.
    - Otherwise: go to GAP.
  - If the counter reaches ACK_TIMEOUT without an ack: drop hop_req; go to FAULT; remain is unchanged.
  - hop_ack while not in WAIT is ignored.
- GAP: hold GAP_CYCLES cycles with hop_req = 0, then go to SELECT. Empty flags are re-sampled in SELECT.
- DONE: done = 1 for exactly one cycle; busy = 0; return to IDLE.
- FAULT:
  - fault = 1, busy = 0; remain_val keeps the unpaid amount.
  - Only reset clears it; charge_ind is ignored.
- Latency from start edge: first hop_req at cycle +3 (edge latch, SELECT, REQ).
- Boundary cases:
  - A 5-yuan hopper going empty mid-payout switches later coins to 1 yuan.
  - Amount 63 with all hoppers full pays 6x5 yuan + 1x1 yuan + 1x0.5 yuan.
  - charge_ind held high across DONE does not retrigger; a new low-to-high edge is required.

Test Plan:
- Reset low 2 cycles, release, charge_val=8, charge_float=0, charge_ind rises, ack each request 3 cycles after hop_req -> hop_sel sequence 10,01,01,01; remain_val 16→6→4→2→0; one done pulse; busy falls with done.
- charge_val=3, charge_float=1 (H=7) -> hop_sel sequence 01,01,01,00; done; fault=0.
- charge_val=10, hop_empty=3'b100 -> ten 1-yuan requests, no 5-yuan request; remain_val 0 at done.
- charge_val=2, hop_empty=3'b011 -> no hop_req; fault=1 within 2 cycles of the start edge; remain_val=4.
- charge_val=5, no acks -> hop_req high for ACK_TIMEOUT cycles, then fault=1; remain_val=10; further charge_ind edges ignored until reset.
- Mid-payout reset after the first ack of charge_val=12 -> all outputs 0 the cycle after reset; a new request of charge_val=1 pays one 1-yuan coin normally.

Source files
------------

// File: rtl/change_dispenser_if.sv
// Bundles the charge request, hopper handshake and status signals between the
// vending-machine top (master) and the change dispenser (slave).
interface change_dispenser_if;
   logic       charge_ind;
   logic [4:0] charge_val;
   logic       charge_float;
   logic [2:0] hop_empty;
   logic       hop_ack;
   logic       hop_req;
   logic [1:0] hop_sel;
   logic       busy;
   logic       done;
   logic       fault;
   logic [5:0] remain_val;

   modport master (
      output charge_ind, charge_val, charge_float, hop_empty, hop_ack,
      input  hop_req, hop_sel, busy, done, fault, remain_val
   );

   modport slave (
      input  charge_ind, charge_val, charge_float, hop_empty, hop_ack,
      output hop_req, hop_sel, busy, done, fault, remain_val
   );
endinterface

// File: rtl/change_dispenser.sv
// Pays out change one coin at a time (greedy 5 / 1 / 0.5 yuan) over a
// request/acknowledge handshake with three hoppers; reports done and a sticky fault.
module change_dispenser #(
   parameter int ACK_TIMEOUT = 16,
   parameter int GAP_CYCLES  = 2,
   parameter int CNT_W       = 5
) (
   input  logic              clk,
   input  logic              reset,
   change_dispenser_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SELECT = 3'd1,
      S_REQ    = 3'd2,
      S_WAIT   = 3'd3,
      S_GAP    = 3'd4,
      S_DONE   = 3'd5,
      S_FAULT  = 3'd6
   } state_e;

   localparam logic [1:0] SEL_5Y   = 2'b10;
   localparam logic [1:0] SEL_1Y   = 2'b01;
   localparam logic [1:0] SEL_HALF = 2'b00;

   // Coin value in half-yuan units for a hopper select code.
   function automatic logic [5:0] coin_weight(input logic [1:0] sel);
      case (sel)
         SEL_5Y:   coin_weight = 6'd10;
         SEL_1Y:   coin_weight = 6'd2;
         SEL_HALF: coin_weight = 6'd1;
         default:  coin_weight = 6'd0;
      endcase
   endfunction

   state_e           state_q, state_d;
   logic [5:0]       remain_q, remain_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ind_q;
   logic             hop_req_q, hop_req_d;
   logic [1:0]       hop_sel_q, hop_sel_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             fault_q, fault_d;

   logic             start_s;
   logic [5:0]       amount_s;
   logic [5:0]       after_coin_s;

   assign start_s      = bus.charge_ind & ~ind_q;
   assign amount_s     = {bus.charge_val, bus.charge_float};
   // SELECT only picks a coin not larger than remain, so this never wraps.
   assign after_coin_s = remain_q - coin_weight(hop_sel_q);

   // State, counters, edge detector and all registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         remain_q  <= 6'd0;
         cnt_q     <= '0;
         ind_q     <= 1'b0;
         hop_req_q <= 1'b0;
         hop_sel_q <= 2'b00;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         remain_q  <= remain_d;
         cnt_q     <= cnt_d;
         ind_q     <= bus.charge_ind;
         hop_req_q <= hop_req_d;
         hop_sel_q <= hop_sel_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         fault_q   <= fault_d;
      end
   end

   // Next-state and next-output logic of the payout sequencer.
   always_comb begin
      state_d   = state_q;
      remain_d  = remain_q;
      cnt_d     = cnt_q;
      hop_req_d = hop_req_q;
      hop_sel_d = hop_sel_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      fault_d   = fault_q;

      case (state_q)
         S_IDLE: begin
            if (start_s) begin
               remain_d = amount_s;
               if (amount_s == 6'd0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d = S_SELECT;
                  busy_d  = 1'b1;
               end
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SELECT: begin
            if ((remain_q >= 6'd10) && !bus.hop_empty[2]) begin
               hop_sel_d = SEL_5Y;
               state_d   = S_REQ;
            end else if ((remain_q >= 6'd2) && !bus.hop_empty[1]) begin
               hop_sel_d = SEL_1Y;
               state_d   = S_REQ;
            end else if ((remain_q >= 6'd1) && !bus.hop_empty[0]) begin
               hop_sel_d = SEL_HALF;
               state_d   = S_REQ;
            end else begin
               state_d = S_FAULT;
               fault_d = 1'b1;
               busy_d  = 1'b0;
            end
         end
         S_REQ: begin
            hop_req_d = 1'b1;
            cnt_d     = '0;
            state_d   = S_WAIT;
         end
         S_WAIT: begin
            if (bus.hop_ack) begin
               hop_req_d = 1'b0;
               remain_d  = after_coin_s;
               cnt_d     = '0;
               if (after_coin_s == 6'd0) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                  busy_d  = 1'b0;
               end else begin
                  state_d = S_GAP;
               end
            end else if (cnt_q == CNT_W'(ACK_TIMEOUT - 1)) begin
               hop_req_d = 1'b0;
               state_d   = S_FAULT;
               fault_d   = 1'b1;
               busy_d    = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_GAP: begin
            if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
               cnt_d   = '0;
               state_d = S_SELECT;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         S_FAULT: begin
            fault_d = 1'b1;
            busy_d  = 1'b0;
            state_d = S_FAULT;
         end
         default: begin
            state_d   = S_IDLE;
            hop_req_d = 1'b0;
            busy_d    = 1'b0;
         end
      endcase
   end

   assign bus.hop_req    = hop_req_q;
   assign bus.hop_sel    = hop_sel_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.fault      = fault_q;
   assign bus.remain_val = remain_q;

endmodule
